// File: rtl/weight_reader.sv
// Snapshots nine trained weights/biases on start and streams them out over a
// valid/ready port, optionally followed by a modulo-2^32 checksum word.
module weight_reader #(
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic [31:0] W1,
  input  logic [31:0] W2,
  input  logic [31:0] W3,
  input  logic [31:0] W4,
  input  logic [31:0] W5,
  input  logic [31:0] W6,
  input  logic [31:0] B0,
  input  logic [31:0] B1,
  input  logic [31:0] B2,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_index,
  output logic        out_last
);

  // state | meaning
  // IDLE  | waiting for start; outputs hold their last values
  // SEND  | streaming snapshot words, one per accepted transfer
  // DONE  | single-cycle done pulse, then back to IDLE
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_IDX = CHECKSUM_EN ? 4'd9 : 4'd8;

  logic [1:0]  state;
  logic [31:0] snap [0:8];
  logic [31:0] sum_q;
  logic [31:0] in_sum;
  logic [3:0]  nxt_idx;
  logic [31:0] nxt_word;
  logic        xfer;

  // checksum is formed from the live inputs at the capture edge, so it always
  // matches the snapshot taken on the same edge
  assign in_sum  = W1 + W2 + W3 + W4 + W5 + W6 + B0 + B1 + B2;
  assign nxt_idx = out_index + 4'd1;
  assign xfer    = out_valid && out_ready;

  always_comb begin
    nxt_word = 32'd0;
    case (nxt_idx)
      4'd1: nxt_word = snap[1];
      4'd2: nxt_word = snap[2];
      4'd3: nxt_word = snap[3];
      4'd4: nxt_word = snap[4];
      4'd5: nxt_word = snap[5];
      4'd6: nxt_word = snap[6];
      4'd7: nxt_word = snap[7];
      4'd8: nxt_word = snap[8];
      4'd9: nxt_word = sum_q;
      default: nxt_word = 32'd0;
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_index <= 4'd0;
      out_last  <= 1'b0;
      sum_q     <= 32'd0;
      for (int i = 0; i < 9; i++) snap[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap[0]   <= W1;
            snap[1]   <= W2;
            snap[2]   <= W3;
            snap[3]   <= W4;
            snap[4]   <= W5;
            snap[5]   <= W6;
            snap[6]   <= B0;
            snap[7]   <= B1;
            snap[8]   <= B2;
            sum_q     <= in_sum;
            out_data  <= W1;
            out_index <= 4'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_index <= nxt_idx;
              out_data  <= nxt_word;
              out_last  <= (nxt_idx == LAST_IDX);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_reader.sv
// Scoreboard bench for weight_reader: one instance with checksum, one without,
// sharing weights, reset and out_ready.
module tb_weight_reader;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } word_t;

  logic        Clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] W1 = 0, W2 = 0, W3 = 0, W4 = 0, W5 = 0, W6 = 0, B0 = 0, B1 = 0, B2 = 0;
  logic        start = 1'b0, start0 = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, done, out_valid, out_last;
  logic [31:0] out_data;
  logic [3:0]  out_index;
  logic        busy0, done0, out_valid0, out_last0;
  logic [31:0] out_data0;
  logic [3:0]  out_index0;

  int total = 0;
  int bad = 0;
  word_t q[$];
  word_t q0[$];
  bit exp_done = 0, exp_done0 = 0;

  always #5 Clock = ~Clock;

  weight_reader #(.CHECKSUM_EN(1'b1)) dut (
    .Clock(Clock), .reset(reset),
    .W1(W1), .W2(W2), .W3(W3), .W4(W4), .W5(W5), .W6(W6),
    .B0(B0), .B1(B1), .B2(B2),
    .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last)
  );

  weight_reader #(.CHECKSUM_EN(1'b0)) dut0 (
    .Clock(Clock), .reset(reset),
    .W1(W1), .W2(W2), .W3(W3), .W4(W4), .W5(W5), .W6(W6),
    .B0(B0), .B1(B1), .B2(B2),
    .start(start0), .busy(busy0), .done(done0),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_index(out_index0), .out_last(out_last0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops on every accepted transfer and checks the done pulse timing
  always @(negedge Clock) begin
    word_t e;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("dut unexpected word", {28'd0, out_index}, 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        check("dut data", out_data, e.data);
        check("dut index", {28'd0, out_index}, {28'd0, e.idx});
        check("dut last", {31'd0, out_last}, {31'd0, e.last});
        check("dut busy", {31'd0, busy}, 32'd1);
        if (e.last) exp_done = 1;
      end
    end else if (exp_done) begin
      check("dut done pulse", {31'd0, done}, 32'd1);
      check("dut busy in done", {31'd0, busy}, 32'd0);
      exp_done = 0;
    end else if (done) begin
      check("dut spurious done", {31'd0, done}, 32'd0);
    end
    if (out_valid0 && out_ready) begin
      if (q0.size() == 0) check("dut0 unexpected word", {28'd0, out_index0}, 32'hFFFF_FFFF);
      else begin
        e = q0.pop_front();
        check("dut0 data", out_data0, e.data);
        check("dut0 index", {28'd0, out_index0}, {28'd0, e.idx});
        check("dut0 last", {31'd0, out_last0}, {31'd0, e.last});
        if (e.last) exp_done0 = 1;
      end
    end else if (exp_done0) begin
      check("dut0 done pulse", {31'd0, done0}, 32'd1);
      exp_done0 = 0;
    end else if (done0) begin
      check("dut0 spurious done", {31'd0, done0}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [31:0] v[9]);
    W1 = v[0]; W2 = v[1]; W3 = v[2]; W4 = v[3]; W5 = v[4];
    W6 = v[5]; B0 = v[6]; B1 = v[7]; B2 = v[8];
  endtask

  task automatic expect_dump(input logic [31:0] v[9], input logic [31:0] cks, input bit to_dut0);
    for (int i = 0; i < 9; i++) begin
      if (to_dut0) q0.push_back('{data: v[i], idx: 4'(i), last: (i == 8)});
      else         q.push_back('{data: v[i], idx: 4'(i), last: 1'b0});
    end
    if (!to_dut0) q.push_back('{data: cks, idx: 4'd9, last: 1'b1});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q.size() != 0 || q0.size() != 0 || exp_done || exp_done0) && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL %s drain timeout: q=%0d q0=%0d expected 0", name, q.size(), q0.size());
    end
    tick();
    tick();
  endtask

  task automatic check_zero(input string name);
    check({name, " valid"}, {31'd0, out_valid}, 32'd0);
    check({name, " data"}, out_data, 32'd0);
    check({name, " index"}, {28'd0, out_index}, 32'd0);
    check({name, " last"}, {31'd0, out_last}, 32'd0);
    check({name, " busy"}, {31'd0, busy}, 32'd0);
    check({name, " done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] v[9];
    @(negedge Clock);
    check_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // basic dump 1..9, checksum 45
    v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    load(v);
    expect_dump(v, 32'd45, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    drain("basic");

    // backpressure at index 2
    expect_dump(v, 32'd45, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 20 && out_index != 4'd2; n++) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp hold data", out_data, 32'd3);
      check("bp hold index", {28'd0, out_index}, 32'd2);
      check("bp hold valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    drain("backpressure");

    // snapshot and overflow
    v = '{default: 32'h7FFF_FFFF};
    load(v);
    expect_dump(v, 32'h7FFF_FFF7, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    v = '{default: 32'd0};
    load(v);
    drain("overflow");

    // negative weight, no checksum instance
    v = '{32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    load(v);
    expect_dump(v, 32'd0, 1'b1);
    start0 = 1'b1; tick(); start0 = 1'b0;
    drain("no checksum");

    // start while busy, then reset mid-dump
    v = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80, 32'd90};
    load(v);
    expect_dump(v, 32'd450, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 20 && out_index != 4'd3; n++) tick();
    v = '{default: 32'd5};
    load(v);
    start = 1'b1; tick(); start = 1'b0;
    check("restart ignored index", {28'd0, out_index}, 32'd4);
    reset = 1'b1;
    q.delete();
    exp_done = 0;
    @(negedge Clock);
    check_zero("mid reset");
    tick(); tick();
    check_zero("held reset");
    reset = 1'b0;
    tick();
    check_zero("after reset");

    // fresh dump after reset
    v = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd500, 32'd600, 32'd700, 32'd800, 32'd900};
    load(v);
    expect_dump(v, 32'd4500, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    check("fresh index", {28'd0, out_index}, 32'd0);
    drain("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
